// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one Rsa256Core between two requesters.
// Latches job operands, sequences start/finished, and aborts a hung core via a watchdog.
module rsa_job_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [255:0] i_a0,
    input  logic [255:0] i_e0,
    input  logic [255:0] i_n0,
    input  logic [255:0] i_a1,
    input  logic [255:0] i_e1,
    input  logic [255:0] i_n1,
    output logic [1:0]   o_rsp_valid,
    input  logic [1:0]   i_rsp_ready,
    output logic [255:0] o_rsp_data,
    output logic         o_rsp_err,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_e,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished,
    output logic         o_core_rst,
    output logic [2:0]   o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // requesters hold valid and operands stable until that edge.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ABORT     = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic             winner;
    logic             accept;
    logic             abort_hold;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_next;
    logic             timeout;
    logic [1:0]       owner_onehot;

    always_comb begin
        winner = 1'b0;
        if (i_req_valid == 2'b11) begin
            winner = ~last_grant;
        end else if (i_req_valid == 2'b10) begin
            winner = 1'b1;
        end
        accept      = (state == ST_IDLE) && (i_req_valid != 2'b00);
        o_req_ready = 2'b00;
        if (accept) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    // The start cycle counts as cycle 1, so the abort lands exactly
    // TIMEOUT_CYCLES after the start pulse.
    assign wd_next      = wd_cnt + CNT_W'(1);
    assign timeout      = (wd_next == TIMEOUT_VAL);
    assign owner_onehot = {owner, ~owner};
    assign o_dbg_state  = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            wd_cnt       <= '0;
            abort_hold   <= 1'b0;
            o_rsp_valid  <= 2'b00;
            o_rsp_data   <= '0;
            o_rsp_err    <= 1'b0;
            o_core_start <= 1'b0;
            o_core_rst   <= 1'b0;
            o_core_a     <= '0;
            o_core_e     <= '0;
            o_core_n     <= '0;
        end else begin
            o_core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_core_a     <= winner ? i_a1 : i_a0;
                        o_core_e     <= winner ? i_e1 : i_e0;
                        o_core_n     <= winner ? i_n1 : i_n0;
                        owner        <= winner;
                        wd_cnt       <= '0;
                        o_core_start <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= CNT_W'(1);
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    wd_cnt <= wd_next;
                    if (timeout) begin
                        o_core_rst <= 1'b1;
                        abort_hold <= 1'b0;
                        state      <= ST_ABORT;
                    end else if (state == ST_WAIT_BUSY) begin
                        // finished is still high from before the start; wait for it to drop
                        if (!i_core_finished) begin
                            state <= ST_WAIT_DONE;
                        end
                    end else if (i_core_finished) begin
                        o_rsp_data  <= i_core_result;
                        o_rsp_err   <= 1'b0;
                        o_rsp_valid <= owner_onehot;
                        state       <= ST_RESP;
                    end
                end
                ST_ABORT: begin
                    if (!abort_hold) begin
                        abort_hold <= 1'b1;
                    end else begin
                        o_core_rst  <= 1'b0;
                        o_rsp_data  <= '0;
                        o_rsp_err   <= 1'b1;
                        o_rsp_valid <= owner_onehot;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready[owner]) begin
                        o_rsp_valid <= 2'b00;
                        last_grant  <= owner;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: behavioural core stub, job drivers, and a
// transaction-level scoreboard of expected responses, grants and pulses.
module tb_rsa_job_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   o_req_ready;
    logic [255:0] a0 = '0, e0 = '0, n0 = '0, a1 = '0, e1 = '0, n1 = '0;
    logic [1:0]   o_rsp_valid;
    logic [1:0]   rsp_ready = 2'b11;
    logic [255:0] o_rsp_data;
    logic         o_rsp_err;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_e, o_core_n;
    logic [255:0] core_result = '0;
    logic         core_finished = 1'b1;
    logic         o_core_rst;
    logic [2:0]   o_dbg_state;

    rsa_job_arbiter #(.TIMEOUT_CYCLES(100), .CNT_W(18)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_a0(a0), .i_e0(e0), .i_n0(n0), .i_a1(a1), .i_e1(e1), .i_n1(n1),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_core_start(o_core_start),
        .o_core_a(o_core_a), .o_core_e(o_core_e), .o_core_n(o_core_n),
        .i_core_result(core_result), .i_core_finished(core_finished),
        .o_core_rst(o_core_rst), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // a^e mod n for operands whose modulus fits in 32 bits
    function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] e,
                                            input logic [255:0] n);
        logic [63:0] r, b, m;
        m = n[63:0];
        r = 64'd1 % m;
        b = a[63:0] % m;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return {192'd0, r};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- core stub ----------------
    logic         hang = 1'b0;
    int           core_lat = 0;
    int           core_cnt = 0;
    logic [255:0] core_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_finished <= 1'b1;
            core_cnt      <= 0;
            core_result   <= '0;
        end else if (o_core_rst) begin
            core_finished <= 1'b1;
            core_cnt      <= 0;
        end else if (o_core_start) begin
            core_finished <= 1'b0;
            core_cnt      <= (core_lat != 0) ? core_lat : int'($urandom_range(2, 30));
            if (hang) core_pend <= '0;
            else core_pend <= modexp(o_core_a, o_core_e, o_core_n);
        end else if (!core_finished && !hang) begin
            if (core_cnt <= 1) begin
                core_finished <= 1'b1;
                core_result   <= core_pend;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // ---------------- requester drivers ----------------
    logic [767:0] jq0[$];
    logic [767:0] jq1[$];
    logic         rand_gap = 1'b0;
    logic [1:0]   drv_acc = 2'b00;

    task automatic push(input int r, input logic [255:0] a, input logic [255:0] e,
                        input logic [255:0] n);
        if (r == 0) jq0.push_back({a, e, n});
        else jq1.push_back({a, e, n});
    endtask

    task automatic push_rand(input int r);
        logic [255:0] n, a, e;
        n = {224'd0, 32'($urandom_range(3, 32'h7fff_ffff) | 1)};
        a = {224'd0, 32'($urandom % n[31:0])};
        e = {224'd0, 32'($urandom)};
        push(r, a, e, n);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            req_valid = 2'b00;
        end else begin
            if (drv_acc[0]) req_valid[0] = 1'b0;
            if (drv_acc[1]) req_valid[1] = 1'b0;
            if (!req_valid[0] && jq0.size() > 0 && !(rand_gap && $urandom_range(0, 2) == 0)) begin
                {a0, e0, n0} = jq0.pop_front();
                req_valid[0] = 1'b1;
            end
            if (!req_valid[1] && jq1.size() > 0 && !(rand_gap && $urandom_range(0, 2) == 0)) begin
                {a1, e1, n1} = jq1.pop_front();
                req_valid[1] = 1'b1;
            end
        end
    end

    // sample handshake-side signals once inputs have settled for the coming edge
    logic [1:0]   smp_valid = 0, smp_ready = 0, smp_rsp_valid = 0, smp_rsp_ready = 0;
    logic         smp_rsp_err = 0;
    logic [255:0] smp_rsp_data = '0;

    always @(negedge clk) begin
        #2;
        smp_valid     = req_valid;
        smp_ready     = o_req_ready;
        smp_rsp_valid = o_rsp_valid;
        smp_rsp_ready = rsp_ready;
        smp_rsp_err   = o_rsp_err;
        smp_rsp_data  = o_rsp_data;
        drv_acc       = rst_n ? (req_valid & o_req_ready) : 2'b00;
    end

    // ---------------- scoreboard / model ----------------
    logic [257:0] exp_q[$];      // {err, owner, data}
    logic [257:0] rsp_log[$];
    logic         grant_log[$];
    logic         m_busy = 0, m_last = 1, m_hang_job = 0;
    logic [255:0] m_a = '0, m_e = '0, m_n = '0;
    int           cyc = 0, m_start_cyc = 0, rsp_cnt = 0, start_cnt = 0;
    int           rst_hi_cnt = 0, rst_delta = -1;
    logic [1:0]   cp_exp_rdy, cp_hs_req, cp_hs_rsp, cp_last_rv = 0;
    logic         cp_own, cp_start_due = 0, cp_fin_due = 0, cp_fin_last = 1;
    logic         cp_rst_last = 0, cp_exp_rst, cp_last_re = 0;
    logic [255:0] cp_last_rd = '0;
    logic [257:0] cp_exp;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 0; m_last = 1; cp_start_due = 0; cp_fin_due = 0;
            cp_fin_last = 1; cp_last_rv = 0; cp_rst_last = 0;
        end else begin
            if (m_busy) cp_exp_rdy = 2'b00;
            else if (smp_valid == 2'b11) cp_exp_rdy = m_last ? 2'b01 : 2'b10;
            else cp_exp_rdy = smp_valid;
            check("req_ready", {258'd0, smp_ready}, {258'd0, cp_exp_rdy});
            cp_hs_req = smp_valid & smp_ready;
            cp_hs_rsp = smp_rsp_valid & smp_rsp_ready;
            cyc++;
            if (cp_hs_rsp != 2'b00) begin
                rsp_log.push_back({smp_rsp_err, cp_hs_rsp[1], smp_rsp_data});
                rsp_cnt++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_last = cp_hs_rsp[1];
                m_busy = 0;
            end
            cp_start_due = 0;
            if (cp_hs_req != 2'b00) begin
                cp_own = cp_hs_req[1];
                if (cp_own) begin m_a = a1; m_e = e1; m_n = n1; end
                else begin m_a = a0; m_e = e0; m_n = n0; end
                if (hang) cp_exp = {1'b1, cp_own, 256'd0};
                else cp_exp = {1'b0, cp_own, modexp(m_a, m_e, m_n)};
                exp_q.push_back(cp_exp);
                grant_log.push_back(cp_own);
                m_busy = 1; m_hang_job = hang; m_start_cyc = cyc; cp_start_due = 1;
            end
            #1;
            check("core_start", {259'd0, o_core_start}, {259'd0, cp_start_due});
            if (o_core_start) start_cnt++;
            cp_exp_rst = m_busy && m_hang_job &&
                         ((cyc - m_start_cyc) == 100 || (cyc - m_start_cyc) == 101);
            check("core_rst", {259'd0, o_core_rst}, {259'd0, cp_exp_rst});
            if (o_core_rst) begin
                rst_hi_cnt++;
                if (!cp_rst_last) rst_delta = cyc - m_start_cyc;
            end
            cp_rst_last = o_core_rst;
            if (m_busy) begin
                check("core_a", {4'd0, o_core_a}, {4'd0, m_a});
                check("core_e", {4'd0, o_core_e}, {4'd0, m_e});
                check("core_n", {4'd0, o_core_n}, {4'd0, m_n});
            end
            if (exp_q.size() > 0) cp_exp = exp_q[0];
            if (cp_fin_due && exp_q.size() > 0)
                check("rsp_latency", {258'd0, o_rsp_valid}, {258'd0, cp_exp[256], ~cp_exp[256]});
            if (o_rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {258'd0, o_rsp_valid}, 260'd0);
                end else begin
                    check("rsp_valid", {258'd0, o_rsp_valid}, {258'd0, cp_exp[256], ~cp_exp[256]});
                    check("rsp_data", {3'd0, o_rsp_err, o_rsp_data}, {3'd0, cp_exp[257], cp_exp[255:0]});
                end
            end
            if (cp_last_rv != 2'b00 && cp_hs_rsp == 2'b00)
                check("rsp_hold", {1'b0, o_rsp_valid, o_rsp_err, o_rsp_data},
                      {1'b0, cp_last_rv, cp_last_re, cp_last_rd});
            cp_fin_due  = m_busy && !m_hang_job && core_finished && !cp_fin_last;
            cp_fin_last = core_finished;
            cp_last_rv  = o_rsp_valid;
            cp_last_re  = o_rsp_err;
            cp_last_rd  = o_rsp_data;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic wait_rsp(input int target, input int budget, input string name);
        int k = 0;
        while (rsp_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, rsp_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base, s0, g0, k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {258'd0, o_rsp_valid}, 260'd0);
        check("rst_rsp_data", {4'd0, o_rsp_data}, 260'd0);
        check("rst_rsp_err", {259'd0, o_rsp_err}, 260'd0);
        check("rst_core_start", {259'd0, o_core_start}, 260'd0);
        check("rst_core_rst", {259'd0, o_core_rst}, 260'd0);
        check("rst_core_a", {4'd0, o_core_a}, 260'd0);
        check("rst_req_ready", {258'd0, o_req_ready}, 260'd0);
        rst_n = 1'b1;

        check("model_2_10", {4'd0, modexp(256'd2, 256'd10, 256'd1009)}, 260'd15);
        check("model_3_5", {4'd0, modexp(256'd3, 256'd5, 256'd1009)}, 260'd243);
        check("model_5_3", {4'd0, modexp(256'd5, 256'd3, 256'd1009)}, 260'd125);

        // single job on requester 0
        base = rsp_cnt; s0 = start_cnt;
        push(0, 256'd2, 256'd10, 256'd1009);
        wait_rsp(base + 1, 200, "t1_done");
        check("t1_rsp", {2'd0, rsp_log[rsp_log.size()-1]}, {2'd0, 1'b0, 1'b0, 256'd15});
        check("t1_starts", start_cnt - s0, 1);

        // simultaneous requests right after reset
        do_reset();
        base = rsp_cnt;
        push(0, 256'd3, 256'd5, 256'd1009);
        push(1, 256'd5, 256'd3, 256'd1009);
        wait_rsp(base + 2, 300, "t2_done");
        if (rsp_log.size() >= base + 2) begin
            check("t2_first", {2'd0, rsp_log[base]}, {2'd0, 1'b0, 1'b0, 256'd243});
            check("t2_second", {2'd0, rsp_log[base+1]}, {2'd0, 1'b0, 1'b1, 256'd125});
        end

        // continuous contention: strict alternation
        base = rsp_cnt; g0 = grant_log.size();
        for (int i = 0; i < 2; i++) begin push_rand(0); push_rand(1); end
        wait_rsp(base + 4, 500, "t3_done");
        for (int i = 0; i < 4; i++)
            if (grant_log.size() > g0 + i)
                check("t3_grant", {259'd0, grant_log[g0+i]}, {259'd0, 1'(i % 2)});

        // response backpressure
        rsp_ready = 2'b00;
        base = rsp_cnt;
        push(0, 256'd3, 256'd5, 256'd1009);
        push(1, 256'd5, 256'd3, 256'd1009);
        k = 0;
        while (o_rsp_valid == 2'b00 && k < 200) begin @(negedge clk); k++; end
        s0 = start_cnt; g0 = grant_log.size();
        repeat (50) @(negedge clk);
        check("t4_starts", start_cnt - s0, 0);
        check("t4_grants", grant_log.size() - g0, 0);
        check("t4_valid", {258'd0, o_rsp_valid}, 260'd1);
        check("t4_data", {4'd0, o_rsp_data}, 260'd243);
        rsp_ready = 2'b11;
        wait_rsp(base + 2, 300, "t4_done");

        // hung core: watchdog abort, then a normal job
        hang = 1'b1;
        base = rsp_cnt; s0 = rst_hi_cnt; rst_delta = -1;
        push(0, rand256(), rand256(), rand256());
        wait_rsp(base + 1, 400, "t5_done");
        hang = 1'b0;
        check("t5_rsp", {2'd0, rsp_log[rsp_log.size()-1]}, {2'd0, 1'b1, 1'b0, 256'd0});
        check("t5_rst_len", rst_hi_cnt - s0, 2);
        check("t5_rst_at", rst_delta, 100);
        push(1, 256'd2, 256'd10, 256'd1009);
        wait_rsp(base + 2, 200, "t5_next");
        check("t5_next_rsp", {2'd0, rsp_log[rsp_log.size()-1]}, {2'd0, 1'b0, 1'b1, 256'd15});

        // randomized traffic with random response backpressure
        rand_gap = 1'b1;
        base = rsp_cnt;
        for (int i = 0; i < 10; i++) begin push_rand(0); push_rand(1); end
        k = 0;
        while (rsp_cnt < base + 20 && k < 4000) begin
            @(negedge clk);
            rsp_ready = 2'($urandom_range(0, 3));
            k++;
        end
        check("t6_done", rsp_cnt, base + 20);
        rand_gap = 1'b0;
        rsp_ready = 2'b11;

        // reset while the core is busy
        core_lat = 20;
        base = rsp_cnt;
        push(0, 256'd7, 256'd11, 256'd1009);
        k = 0;
        while (core_finished && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rsp_valid", {258'd0, o_rsp_valid}, 260'd0);
        check("t7_rsp_data", {4'd0, o_rsp_data}, 260'd0);
        check("t7_core_start", {259'd0, o_core_start}, 260'd0);
        check("t7_core_rst", {259'd0, o_core_rst}, 260'd0);
        check("t7_core_a", {4'd0, o_core_a}, 260'd0);
        repeat (3) @(negedge clk);
        check("t7_no_rsp", rsp_cnt, base);
        rst_n = 1'b1;
        core_lat = 0;
        push(1, 256'd2, 256'd10, 256'd1009);
        wait_rsp(base + 1, 200, "t7_done");
        check("t7_rsp", {2'd0, rsp_log[rsp_log.size()-1]}, {2'd0, 1'b0, 1'b1, 256'd15});
        repeat (5) @(negedge clk);
        check("t7_no_extra", rsp_cnt, base + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/rsa_job_arbiter.md
# rsa_job_arbiter

Two-requester round-robin scheduler that shares a single `Rsa256Core` modular-exponentiation engine (a^e mod n, 256-bit). It accepts jobs over valid/ready handshakes and latches their operands. It sequences the core's start/finished protocol and returns each result to the owning requester. A watchdog recovers from a hung core by resetting it and returning an error response. It sits between the host-side command paths (e.g. RS232/Avalon wrappers) and the core.

## Interface
- `TIMEOUT_CYCLES`, default 200000: maximum cycles from start pulse to core completion before abort.
- `CNT_W`, default 18: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- `i_clk` input 1: the single clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_req_valid` input 2: per-requester job valid.
- `o_req_ready` input-side output 2: per-requester job accept.
- `i_a0`, `i_e0`, `i_n0` input 256 each: requester 0 operands.
- `i_a1`, `i_e1`, `i_n1` input 256 each: requester 1 operands.
- `o_rsp_valid` output 2: per-requester response valid.
- `i_rsp_ready` input 2: per-requester response accept.
- `o_rsp_data` output 256: result, shared by both requesters.
- `o_rsp_err` output 1: response is a timeout abort.
- `o_core_start` output 1: single-cycle start pulse to the core.
- `o_core_a`, `o_core_e`, `o_core_n` output 256 each: latched operands, stable for the whole job.
- `i_core_result` input 256: core result (`o_a_pow_e`).
- `i_core_finished` input 1: core idle flag; high whenever the core is idle.
- `o_core_rst` output 1: active-high reset to the core.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, RESP.
- **IDLE**
  - Winner = round-robin over `i_req_valid`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `o_req_ready[winner]=1` combinationally; the other ready bit is 0.
  - On valid&&ready: latch the winner's a/e/n into the core operand registers, record `owner`, clear the watchdog, go to ISSUE.
- **ISSUE**
  - `o_core_start=1` for exactly this cycle.
  - Watchdog starts counting.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - Wait for `i_core_finished==0`; the core drops `finished` one cycle after sampling start. Then go to WAIT_DONE.
  - Required so the controller never mistakes pre-start idle for completion.
- **WAIT_DONE**
  - On `i_core_finished==1`: latch `i_core_result` into `o_rsp_data`, set `o_rsp_err=0`, go to RESP.
- **Watchdog**
  - Increments every cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: go to ABORT. Timeout takes priority over a same-cycle finished.
- **ABORT**
  - `o_core_rst=1` for 2 cycles.
  - Then `o_rsp_data=0`, `o_rsp_err=1`, go to RESP.
- **RESP**
  - `o_rsp_valid[owner]=1`; data and err held stable.
  - On `i_rsp_ready[owner]`: set `last_grant=owner`, go to IDLE.
  - `i_rsp_ready` of the non-owner is ignored.
- **Exclusivity:** no new job is accepted outside IDLE. `o_req_ready=0` in all other states. One job is in flight at a time.
- **Requester rules:** requesters must hold valid and operands stable until accepted. A dropped valid in IDLE simply re-arbitrates.
- **Operand format:** passed through unchanged. n must be odd and a < n; the core's Montgomery flow requires this. The arbiter does not check it.

## Timing
- **Reset values:** state=IDLE, `o_req_ready`=0 while no valid, `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_err`=0, `o_core_start`=0, `o_core_rst`=0, operand registers=0, `last_grant`=1, watchdog=0.
- **Accept to start:** acceptance at edge T; `o_core_start` is high in cycle T..T+1.
- **Finished to response:** finished observed high at edge D; `o_rsp_valid` is high from D onward (one registered cycle).
- **Back-to-back throughput:** the earliest next acceptance is the cycle after the response handshake, since IDLE is re-entered.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- **Mid-operation reset:** async `i_rst_n` low returns everything to reset values immediately. The in-flight job is dropped with no response. `o_core_rst` is 0 during and after reset; the core has its own reset tie-in at system level.
- **Outputs:** all outputs are registered except `o_req_ready`, which is combinational from state, `i_req_valid` and `last_grant`.

## Test plan
- **Single job, requester 0:** a=2, e=10, n=1009 on requester 0 with a real core -> `o_rsp_valid[0]`, `o_rsp_data`=15, `o_rsp_err`=0, exactly one start pulse.
- **Simultaneous requests after reset:**
  - Requester 0 job is a=3, e=5, n=1009 -> 243.
  - Requester 1 job is a=5, e=3, n=1009 -> 125.
  - Both valid in the same cycle after reset -> requester 0 served first (243), then requester 1 (125). Responses are steered only to the owner.
- **Continuous contention:** both requesters continuously valid for 4 jobs -> grant order 0,1,0,1; `o_req_ready` never high for both.
- **Response backpressure:** hold `i_rsp_ready`=0 for 50 cycles -> valid and data stable, no new acceptance, `o_core_start` stays 0.
- **Hung core:** stub core keeps finished low forever, TIMEOUT_CYCLES=100 -> abort at 100 cycles after start, `o_core_rst` high 2 cycles, response err=1, data=0. The next job completes normally.
- **Reset mid-job:** assert `i_rst_n`=0 during WAIT_DONE -> all outputs return to reset values asynchronously, no response issued. After release, a new job a=2, e=10, n=1009 returns 15.
